// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle combinational product.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [4:0]            rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2:0]     op;
  logic [4:0]     rd_hold;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic           neg;

  // Operand conditioning at the start edge
  logic         a_signed, b_signed, sign_a, sign_b;
  logic [W-1:0] abs_a, abs_b;
  logic         is_div, div_zero, div_ovf, start_neg;

  always_comb begin
    a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a    = a_signed & op_a[W-1];
    sign_b    = b_signed & op_b[W-1];
    abs_a     = sign_a ? -op_a : op_a;
    abs_b     = sign_b ? -op_b : op_b;
    is_div    = funct3[2];
    div_zero  = is_div && (op_b == '0);
    div_ovf   = is_div && !funct3[0] && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    start_neg = (is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = {{W{sign_a}}, op_a};
    fast_b    = {{W{sign_b}}, op_b};
    fast_prod = fast_a * fast_b;
  end
`endif

  // One iteration of each algorithm; acc is {hi, lo}
  logic [W:0]     mul_sum, rem_sh, rem_diff;
  logic           q_bit;
  logic [2*W-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[W-1:1]};
    rem_sh   = {acc[2*W-1:W], acc[W-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    q_bit    = !rem_diff[W];
    div_next = {(q_bit ? rem_diff[W-1:0] : rem_sh[W-1:0]), acc[W-2:0], q_bit};
  end

  // Sign fix-up and output selection
  logic [2*W-1:0] mul_full;
  logic [W-1:0]   quot, remv, fix_res;

  always_comb begin
    mul_full = neg ? -acc : acc;
    quot     = neg ? -acc[W-1:0] : acc[W-1:0];
    remv     = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op)
      3'b000:                 fix_res = mul_full[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = mul_full[2*W-1:W];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = remv;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op      <= '0;
      rd_hold <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              op      <= funct3;
              rd_hold <= rd_in;
              cnt     <= '0;
              busy    <= 1'b1;
              // Special cases preload {remainder, quotient} so FIX needs no negate.
              if (div_zero) begin
                acc   <= {op_a, {W{1'b1}}};
                neg   <= 1'b0;
                state <= S_FIX;
              end else if (div_ovf) begin
                acc   <= {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
                neg   <= 1'b0;
                state <= S_FIX;
`ifdef MULDIV_FAST_MUL_EN
              end else if (!is_div) begin
                acc   <= fast_prod;
                neg   <= 1'b0;
                busy  <= 1'b0;
                state <= S_FIX;
`endif
              end else begin
                acc   <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
                opnd  <= is_div ? abs_b : abs_a;
                neg   <= start_neg;
                state <= S_CALC;
              end
            end else begin
              state <= S_IDLE;
            end
          end
          S_CALC: begin
            acc <= op[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
          end
          S_FIX: begin
            result <= fix_res;
            rd_out <= rd_hold;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: RV32M ops, special cases, kill, reset and back-to-back issue.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam logic MUL_BUSY = 1'b0;
`else
  localparam int MUL_LAT  = 33;
  localparam logic MUL_BUSY = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issues one op from the current (non-edge) time; returns #1 after the done edge.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat, input logic exp_busy, input int poke_at);
    int cyc;
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
      start = (cyc == poke_at);
    end
    start = 1'b0;
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " result"}, result, exp);
    check({name, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    last_res = exp;
    $display("op %-8s a=%08h b=%08h -> result=%08h rd=%0d cycles=%0d", name, a, b, result, rd_out, cyc);
  endtask

  initial begin
    int dones;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiplies
    run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT, MUL_BUSY, -1);
    run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, MUL_LAT, MUL_BUSY, -1);
    run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, MUL_LAT, MUL_BUSY, -1);
    run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, MUL_LAT, MUL_BUSY, -1);
    run_op("MULH2",  3'b001, 32'hFFFFFFFE, 32'd3,        5'd9,  32'hFFFFFFFF, MUL_LAT, MUL_BUSY, -1);
    // Divides, back-to-back, with a start poked mid-op that must be ignored
    run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33, 1'b1, 5);
    run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33, 1'b1, -1);
    run_op("REMU",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33, 1'b1, 10);
    run_op("DIVU",   3'b101, 32'd100,      32'd7,        5'd13, 32'd14,       33, 1'b1, -1);
    run_op("DIVneg", 3'b100, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 33, 1'b1, -1);
    run_op("REMpos", 3'b110, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        33, 1'b1, -1);
    // Special cases
    run_op("DIV0",   3'b100, 32'd1234,     32'd0,        5'd16, 32'hFFFFFFFF, 1, 1'b1, -1);
    run_op("REMU0",  3'b111, 32'd9,        32'd0,        5'd17, 32'd9,        1, 1'b1, -1);
    run_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1, 1'b1, -1);
    run_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1, 1'b1, -1);

    // Kill during a divide: no done, busy drops, result unchanged
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill busy", {31'd0, busy}, 32'd0);
    check("kill done", {31'd0, done}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    check("kill no done", 32'(dones), 32'd0);
    check("kill result", result, last_res);
    $display("op KILL     done pulses after kill=%0d result=%08h", dones, result);

    // Kill beats a start in the DONE cycle
    run_op("DIVU2",  3'b101, 32'd50, 32'd5, 5'd21, 32'd10, 33, 1'b1, -1);
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    check("killstart busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("killstart idle", {31'd0, busy | done}, 32'd0);
    $display("op KILLSTART busy=%0d done=%0d", busy, done);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd22; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", {27'd0, rd_out}, 32'd0);
    $display("op RESET    busy=%0d done=%0d result=%08h rd=%0d", busy, done, result, rd_out);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("DIVUrst", 3'b101, 32'd100, 32'd7, 5'd23, 32'd14, 33, 1'b1, -1);
    @(posedge clk);
    #1 check("done pulse", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
